play_mode_ctrl: RTL and testbench

Parametrised top-level play-mode controller for the keyboard/tone datapath. It selects among free-play, auto-play and learn sources. Free-play note decode is done internally, with a saturating octave register. Every mode change passes through a timed mute window, and auto/learn sub-blocks receive one-cycle restart pulses on entry. Outputs are registered and feed the tone generator and LED bank.

---
 rtl/play_pkg.sv | 33 +++
 rtl/play_mode_ctrl_if.sv | 41 ++++
 rtl/play_mode_ctrl_key_prio_enc.sv | 20 ++
 rtl/play_mode_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_play_mode_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/play_pkg.sv
// Shared play-mode definitions: one-hot mode codes, controller state encoding
// and the rest-note code used by the free-play decoder.
package play_pkg;

  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_FREE  = 3'b100;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_LEARN = 3'b001;

  localparam int NOTE_REST = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_FREE,
    ST_AUTO,
    ST_LEARN
  } play_state_e;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m == MODE_FREE) || (m == MODE_AUTO) || (m == MODE_LEARN);
  endfunction

  function automatic play_state_e mode_state(input logic [2:0] m);
    case (m)
      MODE_FREE:  return ST_FREE;
      MODE_AUTO:  return ST_AUTO;
      MODE_LEARN: return ST_LEARN;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/play_mode_ctrl_if.sv
// Bundle of source inputs and tone/LED outputs around the play-mode controller.
// master = driving side (keys, mode request, sub-block sources), slave = controller.
interface play_mode_ctrl_if #(
  parameter int NUM_KEYS = 7,
  parameter int NOTE_W   = 4,
  parameter int OCT_W    = 2
);

  logic [NUM_KEYS-1:0] keys;
  logic [2:0]          mode;
  logic                oct_up;
  logic                oct_down;
  logic [NOTE_W-1:0]   note_auto;
  logic [NUM_KEYS-1:0] led_auto;
  logic [OCT_W-1:0]    octave_auto;
  logic [NOTE_W-1:0]   note_learn;
  logic [NUM_KEYS-1:0] led_learn;

  logic [NOTE_W-1:0]   note_out;
  logic [NUM_KEYS-1:0] led_out;
  logic [OCT_W-1:0]    octave_out;
  logic [2:0]          cur_mode;
  logic                auto_start;
  logic                learn_start;
  logic                muting;

  modport master (
    output keys, mode, oct_up, oct_down,
    output note_auto, led_auto, octave_auto, note_learn, led_learn,
    input  note_out, led_out, octave_out, cur_mode,
    input  auto_start, learn_start, muting
  );

  modport slave (
    input  keys, mode, oct_up, oct_down,
    input  note_auto, led_auto, octave_auto, note_learn, led_learn,
    output note_out, led_out, octave_out, cur_mode,
    output auto_start, learn_start, muting
  );

endinterface

// File: rtl/play_mode_ctrl_key_prio_enc.sv
// Free-play key decoder: lowest pressed key index + 1, rest code when no key is down.
module key_prio_enc
  import play_pkg::*;
#(
  parameter int NUM_KEYS = 7,
  parameter int NOTE_W   = 4
) (
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NOTE_W-1:0]   note
);

  // Scan from the top so the lowest set key is the last one written.
  always_comb begin
    note = NOTE_W'(NOTE_REST);
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) note = NOTE_W'(i + 1);
    end
  end

endmodule

// File: rtl/play_mode_ctrl.sv
// Play-mode controller: free/auto/learn source select with timed mute on every switch.
// Optional MODE_DEBOUNCE_EN inserts a DEB_CYCLES stability filter on the mode request.
module play_mode_ctrl
  import play_pkg::*;
#(
  parameter int NUM_KEYS    = 7,
  parameter int NOTE_W      = 4,
  parameter int OCT_W       = 2,
  parameter int OCT_DEFAULT = 1,
  parameter int MUTE_CYCLES = 4,
  parameter int DEB_CYCLES  = 16
) (
  input logic             clk,
  input logic             reset,
  play_mode_ctrl_if.slave bus
);

  localparam int               CNT_W    = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [OCT_W-1:0] OCT_MAX  = '1;
  localparam logic [OCT_W-1:0] OCT_RST  = OCT_W'(OCT_DEFAULT);

  if (MUTE_CYCLES < 1 || DEB_CYCLES < 1 || (2 ** NOTE_W) <= NUM_KEYS) begin : g_param_err
    $error("play_mode_ctrl: illegal parameter combination");
  end

  logic [2:0] mode_f;

`ifdef MODE_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [2:0]       mode_last;
  logic [DEB_W-1:0] deb_cnt;

  // A request is accepted once it has been seen on DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_last <= MODE_NONE;
      deb_cnt   <= '0;
      mode_f    <= MODE_NONE;
    end else if (bus.mode != mode_last) begin
      mode_last <= bus.mode;
      deb_cnt   <= DEB_W'(1);
      if (DEB_CYCLES == 1) mode_f <= bus.mode;
    end else begin
      if (deb_cnt != DEB_W'(DEB_CYCLES)) deb_cnt <= deb_cnt + 1'b1;
      if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) mode_f <= mode_last;
    end
  end
`else
  assign mode_f = bus.mode;
`endif

  play_state_e       state;
  logic [2:0]        target;
  logic [CNT_W-1:0]  cnt;
  logic [OCT_W-1:0]  oct_q;
  logic [OCT_W-1:0]  oct_nxt;
  logic [NOTE_W-1:0] key_note;

  logic [NOTE_W-1:0]   note_p1;
  logic [NUM_KEYS-1:0] led_p1;
  logic [OCT_W-1:0]    oct_p1;
  logic [2:0]          cur_mode_p1;
  logic                auto_start_p1;
  logic                learn_start_p1;
  logic                muting_p1;

  key_prio_enc #(
    .NUM_KEYS (NUM_KEYS),
    .NOTE_W   (NOTE_W)
  ) u_key_prio_enc (
    .keys (bus.keys),
    .note (key_note)
  );

  logic       legal;
  logic       playing;
  logic       hold;
  logic       enter;
  logic [2:0] act_nxt;

  assign legal   = mode_legal(mode_f);
  assign playing = (state == ST_FREE) || (state == ST_AUTO) || (state == ST_LEARN);
  assign hold    = playing && legal && (mode_f == cur_mode_p1);
  assign enter   = (state == ST_SWITCH) && legal && (mode_f == target) && (cnt == '0);
  // Mode that will be active after this edge; MODE_NONE means IDLE or SWITCH.
  assign act_nxt = hold ? cur_mode_p1 : (enter ? target : MODE_NONE);

  always_comb begin
    oct_nxt = oct_q;
    if (state == ST_FREE) begin
      if (bus.oct_up && !bus.oct_down && oct_q != OCT_MAX)
        oct_nxt = oct_q + 1'b1;
      else if (bus.oct_down && !bus.oct_up && oct_q != '0)
        oct_nxt = oct_q - 1'b1;
    end
  end

  // ---- stage p1: state update and registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      target         <= MODE_NONE;
      cnt            <= '0;
      oct_q          <= OCT_RST;
      note_p1        <= '0;
      led_p1         <= '0;
      oct_p1         <= '0;
      cur_mode_p1    <= MODE_NONE;
      auto_start_p1  <= 1'b0;
      learn_start_p1 <= 1'b0;
      muting_p1      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (legal) begin
            target <= mode_f;
            cnt    <= CNT_LOAD;
            state  <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          if (!legal) begin
            state <= ST_IDLE;
          end else if (mode_f != target) begin
            target <= mode_f;
            cnt    <= CNT_LOAD;
          end else if (cnt == '0) begin
            state <= mode_state(target);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (!legal) begin
            state <= ST_IDLE;
          end else if (!hold) begin
            target <= mode_f;
            cnt    <= CNT_LOAD;
            state  <= ST_SWITCH;
          end
        end
      endcase

      oct_q          <= oct_nxt;
      cur_mode_p1    <= act_nxt;
      muting_p1      <= (act_nxt == MODE_NONE);
      auto_start_p1  <= enter && (target == MODE_AUTO);
      learn_start_p1 <= enter && (target == MODE_LEARN);

      case (act_nxt)
        MODE_FREE: begin
          note_p1 <= key_note;
          led_p1  <= bus.keys;
          oct_p1  <= oct_nxt;
        end
        MODE_AUTO: begin
          note_p1 <= bus.note_auto;
          led_p1  <= bus.led_auto;
          oct_p1  <= bus.octave_auto;
        end
        MODE_LEARN: begin
          note_p1 <= bus.note_learn;
          led_p1  <= bus.led_learn;
          oct_p1  <= oct_nxt;
        end
        default: begin
          note_p1 <= NOTE_W'(NOTE_REST);
          led_p1  <= '0;
          oct_p1  <= '0;
        end
      endcase
    end
  end

  assign bus.note_out    = note_p1;
  assign bus.led_out     = led_p1;
  assign bus.octave_out  = oct_p1;
  assign bus.cur_mode    = cur_mode_p1;
  assign bus.auto_start  = auto_start_p1;
  assign bus.learn_start = learn_start_p1;
  assign bus.muting      = muting_p1;

endmodule

// File: tb/tb_play_mode_ctrl.sv
// Bench for play_mode_ctrl: directed scenario followed by randomized traffic,
// every cycle compared against a behavioural model of the mode/mute/octave rules.
module tb_play_mode_ctrl;

  localparam int NUM_KEYS    = 7;
  localparam int NOTE_W      = 4;
  localparam int OCT_W       = 2;
  localparam int OCT_DEFAULT = 1;
  localparam int MUTE_CYCLES = 4;
  localparam int OCT_TOP     = (1 << OCT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  play_mode_ctrl_if #(.NUM_KEYS(NUM_KEYS), .NOTE_W(NOTE_W), .OCT_W(OCT_W)) bus ();

  play_mode_ctrl #(
    .NUM_KEYS    (NUM_KEYS),
    .NOTE_W      (NOTE_W),
    .OCT_W       (OCT_W),
    .OCT_DEFAULT (OCT_DEFAULT),
    .MUTE_CYCLES (MUTE_CYCLES),
    .DEB_CYCLES  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  // Model: phase 0 = silent idle, 1 = mute window running, 2 = playing m_act.
  int         ph;
  logic [2:0] m_act;
  logic [2:0] m_tgt;
  int         m_wait;
  int         m_oct;

  int unsigned e_note, e_led, e_oct, e_mode, e_as, e_ls, e_mute;

  function automatic int lowest_key(input logic [NUM_KEYS-1:0] k);
    for (int i = 0; i < NUM_KEYS; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_step();
    logic [2:0] md;
    bit         legal;
    bit         entered;
    md      = bus.mode;
    legal   = ($countones(md) == 1);
    entered = 0;
    if (reset) begin
      ph    = 0;
      m_act = 3'b000;
      m_oct = OCT_DEFAULT;
    end else begin
      if (ph == 2 && m_act == 3'b100) begin
        if (bus.oct_up && !bus.oct_down && m_oct < OCT_TOP) m_oct = m_oct + 1;
        else if (bus.oct_down && !bus.oct_up && m_oct > 0)  m_oct = m_oct - 1;
      end
      case (ph)
        0: if (legal) begin ph = 1; m_tgt = md; m_wait = MUTE_CYCLES; end
        1: begin
          if (!legal) ph = 0;
          else if (md != m_tgt) begin m_tgt = md; m_wait = MUTE_CYCLES; end
          else begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin ph = 2; m_act = m_tgt; entered = 1; end
          end
        end
        default: begin
          if (!legal) ph = 0;
          else if (md != m_act) begin ph = 1; m_tgt = md; m_wait = MUTE_CYCLES; end
        end
      endcase
    end
    e_note = 0; e_led = 0; e_oct = 0; e_mode = 0; e_mute = 1;
    e_as = (entered && m_act == 3'b010) ? 1 : 0;
    e_ls = (entered && m_act == 3'b001) ? 1 : 0;
    if (ph == 2) begin
      e_mode = m_act;
      e_mute = 0;
      if (m_act == 3'b100) begin
        e_note = lowest_key(bus.keys); e_led = bus.keys; e_oct = m_oct;
      end else if (m_act == 3'b010) begin
        e_note = bus.note_auto; e_led = bus.led_auto; e_oct = bus.octave_auto;
      end else begin
        e_note = bus.note_learn; e_led = bus.led_learn; e_oct = m_oct;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("note_out",    bus.note_out,    e_note);
    check("led_out",     bus.led_out,     e_led);
    check("octave_out",  bus.octave_out,  e_oct);
    check("cur_mode",    bus.cur_mode,    e_mode);
    check("auto_start",  bus.auto_start,  e_as);
    check("learn_start", bus.learn_start, e_ls);
    check("muting",      bus.muting,      e_mute);
  endtask

  initial begin
    int unsigned r;
    logic [2:0]  rm;
    reset           = 1'b1;
    bus.keys        = '0;
    bus.mode        = 3'b000;
    bus.oct_up      = 1'b0;
    bus.oct_down    = 1'b0;
    bus.note_auto   = '0;
    bus.led_auto    = '0;
    bus.octave_auto = '0;
    bus.note_learn  = 4'd6;
    bus.led_learn   = 7'b0100000;
    repeat (2) tick();
    reset = 1'b0;

    bus.mode = 3'b100;
    repeat (6) tick();
    bus.keys = 7'b0010100;
    repeat (2) tick();

    bus.oct_up = 1'b1;
    repeat (3) tick();
    bus.oct_down = 1'b1;
    tick();
    bus.oct_up = 1'b0;
    repeat (4) tick();
    bus.oct_down = 1'b0;
    bus.oct_up   = 1'b1;
    repeat (3) tick();
    bus.oct_up = 1'b0;

    bus.mode        = 3'b010;
    bus.note_auto   = 4'd5;
    bus.octave_auto = 2'd2;
    bus.led_auto    = 7'b1010101;
    repeat (7) tick();
    bus.note_auto = 4'd9;
    repeat (2) tick();

    bus.mode = 3'b100;
    repeat (6) tick();
    bus.mode = 3'b010;
    repeat (2) tick();
    bus.mode = 3'b001;
    repeat (7) tick();
    bus.mode = 3'b110;
    repeat (2) tick();
    bus.mode = 3'b001;
    repeat (7) tick();
    bus.mode = 3'b010;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    bus.mode = 3'b100;
    repeat (7) tick();

    for (int c = 0; c < 2500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 11) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 8) rm = 3'b001 << $urandom_range(0, 2);
        else       rm = 3'($urandom);
        bus.mode = rm;
      end
      bus.keys        = NUM_KEYS'($urandom);
      bus.oct_up      = ($urandom_range(0, 3) == 0);
      bus.oct_down    = ($urandom_range(0, 3) == 0);
      bus.note_auto   = NOTE_W'($urandom);
      bus.led_auto    = NUM_KEYS'($urandom);
      bus.octave_auto = OCT_W'($urandom);
      bus.note_learn  = NOTE_W'($urandom);
      bus.led_learn   = NUM_KEYS'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
